// File: rtl/hazard_unit_if.sv
// Bundle of ID-stage operand/destination inputs, stage results and the
// forwarding/stall/flush controls exchanged with the hazard unit.
interface hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [DATA_W-1:0] id_rd_rs;
  logic [DATA_W-1:0] id_rd_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_wr;
  logic              id_load;
  logic              ex_redirect;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall;
  logic              flush_ifid;
  logic              flush_idex;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Pipeline side: drives the ID/EX-stage information, consumes controls.
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd_rs, id_rd_rt,
           id_dst, id_wr, id_load, ex_redirect, ex_result, mem_result, wb_data,
    input  opa, opb, fwd_a_sel, fwd_b_sel, stall, flush_ifid, flush_idex,
           stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd_rs, id_rd_rt,
           id_dst, id_wr, id_load, ex_redirect, ex_result, mem_result, wb_data,
    output opa, opb, fwd_a_sel, fwd_b_sel, stall, flush_ifid, flush_idex,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline. Shadows the
// destinations of instructions in EX/MEM/WB, forwards operands from the
// youngest producer, stalls on load-use and flushes on taken redirects.
module hazard_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave bus
);

  // Shadow pipeline. WB never needs the load flag: WB data is always final.
  logic              ex_v_q, ex_v_d, mem_v_q, mem_v_d, wb_v_q, wb_v_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
  logic              ex_ld_q, ex_ld_d, mem_ld_q, mem_ld_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic redirect;
  logic ld_hazard;
  logic stall_w;

  // Per-operand match and forwarding mux (gi=0: rs/opa, gi=1: rt/opb).
  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic [REG_AW-1:0] src;
    logic              use_src;
    logic [DATA_W-1:0] rd;
    logic              hit_ex, hit_mem, hit_wb;
    logic [1:0]        sel;
    logic [DATA_W-1:0] op;

    // Match against each shadow stage, then pick the youngest producer.
    always_comb begin
      src     = (gi == 0) ? bus.id_rs     : bus.id_rt;
      use_src = (gi == 0) ? bus.id_use_rs : bus.id_use_rt;
      rd      = (gi == 0) ? bus.id_rd_rs  : bus.id_rd_rt;
      hit_ex  = bus.id_valid & use_src & (src != '0) & ex_v_q  & (ex_dst_q  == src);
      hit_mem = bus.id_valid & use_src & (src != '0) & mem_v_q & (mem_dst_q == src);
      hit_wb  = bus.id_valid & use_src & (src != '0) & wb_v_q  & (wb_dst_q  == src);
      sel = 2'd0;
      op  = rd;
      if (hit_ex) begin
        sel = 2'd1;
        op  = bus.ex_result;
      end else if (hit_mem) begin
        sel = 2'd2;
        op  = bus.mem_result;
      end else if (hit_wb) begin
        sel = 2'd3;
        op  = bus.wb_data;
      end
    end
  end

  // Load-use detection; redirect overrides stall, reset silences both.
  always_comb begin
    ld_hazard = (g_op[0].hit_ex | g_op[1].hit_ex) & ex_ld_q;
    if (LOAD_STALL == 2) begin
      ld_hazard = ld_hazard | ((g_op[0].hit_mem | g_op[1].hit_mem) & mem_ld_q);
    end
    redirect = bus.ex_redirect & ~reset;
    stall_w  = ld_hazard & ~redirect & ~reset;
  end

  // Next shadow state and saturating counters.
  always_comb begin
    ex_v_d    = bus.id_valid & bus.id_wr & ~stall_w & ~redirect;
    ex_dst_d  = bus.id_dst;
    ex_ld_d   = bus.id_load;
    mem_v_d   = ex_v_q;
    mem_dst_d = ex_dst_q;
    mem_ld_d  = ex_ld_q;
    wb_v_d    = mem_v_q;
    wb_dst_d  = mem_dst_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers; reset invalidates every shadow entry and clears counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v_q      <= 1'b0;
      mem_v_q     <= 1'b0;
      wb_v_q      <= 1'b0;
      ex_dst_q    <= '0;
      mem_dst_q   <= '0;
      wb_dst_q    <= '0;
      ex_ld_q     <= 1'b0;
      mem_ld_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      mem_v_q     <= mem_v_d;
      wb_v_q      <= wb_v_d;
      ex_dst_q    <= ex_dst_d;
      mem_dst_q   <= mem_dst_d;
      wb_dst_q    <= wb_dst_d;
      ex_ld_q     <= ex_ld_d;
      mem_ld_q    <= mem_ld_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.opa        = g_op[0].op;
  assign bus.opb        = g_op[1].op;
  assign bus.fwd_a_sel  = g_op[0].sel;
  assign bus.fwd_b_sel  = g_op[1].sel;
  assign bus.stall      = stall_w;
  assign bus.flush_ifid = redirect;
  assign bus.flush_idex = redirect;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them against the addressed instance.
module tb_hazard_unit;

  localparam logic [31:0] EXV  = 32'h1111_0001;
  localparam logic [31:0] MEMV = 32'h2222_0002;
  localparam logic [31:0] WBV  = 32'h3333_0003;
  localparam logic [31:0] RDA  = 32'h4444_0004;
  localparam logic [31:0] RDB  = 32'h5555_0005;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_unit_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) ifa();
  hazard_unit_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  ifb();

  hazard_unit #(.DATA_W(32), .REG_AW(5), .LOAD_STALL(1), .CNT_W(16))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  hazard_unit #(.DATA_W(32), .REG_AW(5), .LOAD_STALL(2), .CNT_W(2))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct {
    int          inst;
    string       nm;
    logic        st;
    logic        fl;
    bit          ca;
    logic [1:0]  sa;
    logic [31:0] oa;
    bit          cb;
    logic [1:0]  sb;
    logic [31:0] ob;
    bit          cs;
    int          sc;
    bit          cf;
    int          fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input int inst, input string nm, input logic st, input logic fl);
    exp_t e;
    e.inst = inst; e.nm = nm; e.st = st; e.fl = fl;
    e.ca = 0; e.sa = 0; e.oa = 0; e.cb = 0; e.sb = 0; e.ob = 0;
    e.cs = 0; e.sc = 0; e.cf = 0; e.fc = 0;
    return e;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0h required %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic st, fi, fx;
      logic [1:0] sa, sb;
      logic [31:0] oa, ob;
      int sc, fc;
      e = exp_q.pop_front();
      if (e.inst == 0) begin
        st = ifa.stall; fi = ifa.flush_ifid; fx = ifa.flush_idex;
        sa = ifa.fwd_a_sel; sb = ifa.fwd_b_sel; oa = ifa.opa; ob = ifa.opb;
        sc = int'(ifa.stall_cnt); fc = int'(ifa.flush_cnt);
      end else begin
        st = ifb.stall; fi = ifb.flush_ifid; fx = ifb.flush_idex;
        sa = ifb.fwd_a_sel; sb = ifb.fwd_b_sel; oa = ifb.opa; ob = ifb.opb;
        sc = int'(ifb.stall_cnt); fc = int'(ifb.flush_cnt);
      end
      cmp(e.nm, "stall", 64'(st), 64'(e.st));
      cmp(e.nm, "flush_ifid", 64'(fi), 64'(e.fl));
      cmp(e.nm, "flush_idex", 64'(fx), 64'(e.fl));
      if (e.ca) begin
        cmp(e.nm, "fwd_a_sel", 64'(sa), 64'(e.sa));
        cmp(e.nm, "opa", 64'(oa), 64'(e.oa));
      end
      if (e.cb) begin
        cmp(e.nm, "fwd_b_sel", 64'(sb), 64'(e.sb));
        cmp(e.nm, "opb", 64'(ob), 64'(e.ob));
      end
      if (e.cs) cmp(e.nm, "stall_cnt", 64'(sc), 64'(e.sc));
      if (e.cf) cmp(e.nm, "flush_cnt", 64'(fc), 64'(e.fc));
      $display("txn %-10s inst=%0d stall=%0b flush=%0b sel_a=%0d sel_b=%0d opa=%h stall_cnt=%0d flush_cnt=%0d",
               e.nm, e.inst, st, fi, sa, sb, oa, sc, fc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID-stage fields of one instance; the other instance is idle.
  task automatic drv(input int inst, input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt, input logic [4:0] dst,
                     input logic wr, input logic ld, input logic rdr);
    if (inst == 0) begin
      ifa.id_valid = v; ifa.id_rs = rs; ifa.id_use_rs = urs; ifa.id_rt = rt;
      ifa.id_use_rt = urt; ifa.id_dst = dst; ifa.id_wr = wr; ifa.id_load = ld;
      ifa.ex_redirect = rdr;
      ifb.id_valid = 1'b0; ifb.ex_redirect = 1'b0;
    end else begin
      ifb.id_valid = v; ifb.id_rs = rs; ifb.id_use_rs = urs; ifb.id_rt = rt;
      ifb.id_use_rt = urt; ifb.id_dst = dst; ifb.id_wr = wr; ifb.id_load = ld;
      ifb.ex_redirect = rdr;
      ifa.id_valid = 1'b0; ifa.ex_redirect = 1'b0;
    end
  endtask

  // Queue a forwarding expectation on operand A with optional stall count.
  task automatic exp_a(input int inst, input string nm, input logic st,
                       input logic [1:0] sa, input logic [31:0] oa,
                       input bit cs, input int sc);
    exp_t e;
    e = mk(inst, nm, st, 1'b0);
    e.ca = 1; e.sa = sa; e.oa = oa; e.cs = cs; e.sc = sc;
    exp_q.push_back(e);
  endtask

  task automatic exp_st(input int inst, input string nm, input logic st, input int sc);
    exp_t e;
    e = mk(inst, nm, st, 1'b0);
    e.cs = 1; e.sc = sc;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    ifa.id_rd_rs = RDA; ifa.id_rd_rt = RDB; ifb.id_rd_rs = RDA; ifb.id_rd_rt = RDB;
    ifa.ex_result = EXV; ifa.mem_result = MEMV; ifa.wb_data = WBV;
    ifb.ex_result = EXV; ifb.mem_result = MEMV; ifb.wb_data = WBV;
    ifa.id_valid = 1'b1; ifa.id_rs = 5'd1; ifa.id_use_rs = 1'b1; ifa.id_rt = 5'd0;
    ifa.id_use_rt = 1'b0; ifa.id_dst = 5'd1; ifa.id_wr = 1'b1; ifa.id_load = 1'b1;
    ifa.ex_redirect = 1'b1;
    ifb.id_valid = 1'b0; ifb.id_rs = 5'd0; ifb.id_use_rs = 1'b0; ifb.id_rt = 5'd0;
    ifb.id_use_rt = 1'b0; ifb.id_dst = 5'd0; ifb.id_wr = 1'b0; ifb.id_load = 1'b0;
    ifb.ex_redirect = 1'b0;

    // Reset: redirect requested but flush must stay low, counters zero.
    cyc();
    cyc();
    for (int i = 0; i < 2; i++) begin
      e = mk(i, "reset", 1'b0, 1'b0);
      e.ca = 1; e.sa = 2'd0; e.oa = RDA; e.cs = 1; e.sc = 0; e.cf = 1; e.fc = 0;
      exp_q.push_back(e);
    end
    cyc();
    reset = 1'b0;
    drv(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // add r3, then three dependents and a far one.
    cyc(); drv(0, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0); exp_a(0, "add_r3", 0, 2'd0, RDA, 0, 0);
    cyc(); drv(0, 1, 5'd3, 1, 5'd3, 0, 5'd9, 0, 0, 0);
    e = mk(0, "dep_n1", 1'b0, 1'b0);
    e.ca = 1; e.sa = 2'd1; e.oa = EXV; e.cb = 1; e.sb = 2'd0; e.ob = RDB;
    exp_q.push_back(e);
    cyc(); drv(0, 1, 5'd3, 1, 5'd0, 0, 5'd9, 0, 0, 0); exp_a(0, "dep_n2", 0, 2'd2, MEMV, 0, 0);
    cyc(); drv(0, 1, 5'd3, 1, 5'd0, 0, 5'd9, 0, 0, 0); exp_a(0, "dep_n3", 0, 2'd3, WBV, 0, 0);
    cyc(); drv(0, 1, 5'd3, 1, 5'd0, 0, 5'd9, 0, 0, 0); exp_a(0, "dep_n4", 0, 2'd0, RDA, 0, 0);

    // Two producers of r5: the EX one wins on both operands.
    cyc(); drv(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    cyc(); drv(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    cyc(); drv(0, 1, 5'd5, 1, 5'd5, 1, 5'd9, 0, 0, 0);
    e = mk(0, "ex_prio", 1'b0, 1'b0);
    e.ca = 1; e.sa = 2'd1; e.oa = EXV; e.cb = 1; e.sb = 2'd1; e.ob = EXV;
    exp_q.push_back(e);

    // Write to r0 then read r0: never forwarded.
    cyc(); drv(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
    cyc(); drv(0, 1, 5'd0, 1, 5'd0, 0, 5'd9, 0, 0, 0); exp_a(0, "r0_read", 0, 2'd0, RDA, 0, 0);

    // Load-use with one stall cycle.
    cyc(); drv(0, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0);
    cyc(); drv(0, 1, 5'd4, 1, 5'd0, 0, 5'd6, 0, 0, 0); exp_st(0, "lu_stall", 1, 0);
    cyc(); drv(0, 1, 5'd4, 1, 5'd0, 0, 5'd6, 0, 0, 0); exp_a(0, "lu_fwd", 0, 2'd2, MEMV, 1, 1);

    // Redirect while a load-use hazard holds.
    cyc(); drv(0, 1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);
    cyc(); drv(0, 1, 5'd7, 1, 5'd0, 0, 5'd6, 0, 0, 1);
    e = mk(0, "redirect", 1'b0, 1'b1);
    e.cs = 1; e.sc = 1; e.cf = 1; e.fc = 0;
    exp_q.push_back(e);
    cyc(); drv(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    e = mk(0, "post_redir", 1'b0, 1'b0);
    e.cs = 1; e.sc = 1; e.cf = 1; e.fc = 1;
    exp_q.push_back(e);

    // Reset in the middle of a stall.
    cyc(); drv(0, 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0);
    cyc(); drv(0, 1, 5'd8, 1, 5'd0, 0, 5'd6, 0, 0, 0); exp_st(0, "pre_rst", 1, 1);
    cyc(); reset = 1'b1;
    e = mk(0, "mid_rst", 1'b0, 1'b0);
    e.ca = 1; e.sa = 2'd0; e.oa = RDA; e.cs = 1; e.sc = 0; e.cf = 1; e.fc = 0;
    exp_q.push_back(e);
    cyc(); reset = 1'b0;
    e = mk(0, "post_rst", 1'b0, 1'b0);
    e.ca = 1; e.sa = 2'd0; e.oa = RDA; e.cs = 1; e.sc = 0; e.cf = 1; e.fc = 0;
    exp_q.push_back(e);

    // LOAD_STALL=2, CNT_W=2: two stalls per load-use, counter saturates at 3.
    for (int k = 0; k < 3; k++) begin
      cyc(); drv(1, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0);
      cyc(); drv(1, 1, 5'd4, 1, 5'd0, 0, 5'd6, 0, 0, 0);
      exp_st(1, $sformatf("lu2_s1_%0d", k), 1, (k == 0) ? 0 : ((k == 1) ? 2 : 3));
      cyc(); drv(1, 1, 5'd4, 1, 5'd0, 0, 5'd6, 0, 0, 0);
      exp_st(1, $sformatf("lu2_s2_%0d", k), 1, (k == 0) ? 1 : 3);
      cyc(); drv(1, 1, 5'd4, 1, 5'd0, 0, 5'd6, 0, 0, 0);
      exp_a(1, $sformatf("lu2_fwd_%0d", k), 0, 2'd3, WBV, 1, (k == 0) ? 2 : 3);
    end

    cyc(); drv(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
